// File: rtl/pip_mem_stage.sv
// rtl/pip_mem_stage.sv - MEM pipeline stage: data-memory handshake, store lane steering, load formatting.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of issuing dm_req.
module pip_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_dmem_ctrl,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rdEn,
  input  logic        ex_MemRead,
  input  logic        ex_DMwriteEn,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_rdEn,
  output logic        misalign_exc
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  logic        state_q,    state_d;
  logic [31:0] alu_q,      alu_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  be_q,       be_d;
  logic [2:0]  ctrl_q,     ctrl_d;
  logic        we_q,       we_d;
  logic [4:0]  rd_q,       rd_d;
  logic        rden_q,     rden_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q,  wb_data_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic        wb_rden_q,  wb_rden_d;
  logic        mis_q,      mis_d;

  logic        mem_op;
  logic        misaligned;
  logic [1:0]  ex_size;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_data;

  assign mem_op = ex_valid & (ex_MemRead | ex_DMwriteEn);

  // Size from funct3[1:0]: 0 byte, 1 half, anything else a word (covers undefined encodings).
  always_comb begin
    ex_size  = (ex_dmem_ctrl[1:0] == 2'b00) ? 2'd0 :
               (ex_dmem_ctrl[1:0] == 2'b01) ? 2'd1 : 2'd2;
    ex_be    = 4'b1111;
    ex_wdata = ex_store_data;
    case (ex_size)
      2'd0: begin
        ex_be    = 4'b0001 << ex_alu_out[1:0];
        ex_wdata = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        ex_be    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
        ex_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        ex_be    = 4'b1111;
        ex_wdata = ex_store_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((ex_size == 2'd1) && ex_alu_out[0]) ||
                      ((ex_size == 2'd2) && (ex_alu_out[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    rdata_shifted = dm_rdata >> {alu_q[1:0], 3'b000};
    rdata_half    = alu_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ctrl_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_half[15]}}, rdata_half};
      3'b100:  load_data = {24'b0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'b0, rdata_half};
      default: load_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_q      <= 32'b0;
      wdata_q    <= 32'b0;
      be_q       <= 4'b0;
      ctrl_q     <= 3'b0;
      we_q       <= 1'b0;
      rd_q       <= 5'b0;
      rden_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'b0;
      wb_rd_q    <= 5'b0;
      wb_rden_q  <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ctrl_q     <= ctrl_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      rden_q     <= rden_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rden_q  <= wb_rden_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ctrl_d     = ctrl_q;
    we_d       = we_q;
    rd_d       = rd_q;
    rden_d     = rden_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_rden_d  = wb_rden_q;
    mis_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          state_d = ST_REQ;
          alu_d   = ex_alu_out;
          wdata_d = ex_wdata;
          be_d    = ex_be;
          ctrl_d  = ex_dmem_ctrl;
          we_d    = ex_DMwriteEn;
          rd_d    = ex_rd;
          rden_d  = ex_rdEn;
        end else if (mem_op) begin
          // Trapped access retires immediately with the faulting address and no regfile write.
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu_out;
          wb_rd_d    = ex_rd;
          wb_rden_d  = 1'b0;
          mis_d      = 1'b1;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu_out;
          wb_rd_d    = ex_rd;
          wb_rden_d  = ex_rdEn;
        end
      end
      default: begin
        if (dm_ack) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? alu_q : load_data;
          wb_rd_d    = rd_q;
          wb_rden_d  = rden_q & ~we_q;
        end
      end
    endcase
  end

  always_comb begin
    dm_req = (state_q == ST_REQ);
    dm_we  = dm_req & we_q;
    dm_be  = dm_req ? be_q : 4'b0;
    if (state_q == ST_REQ) stall = rst_n & ~dm_ack;
    else                   stall = rst_n & mem_op & ~misaligned;
  end

  assign dm_addr      = {alu_q[31:2], 2'b00};
  assign dm_wdata     = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_rdEn      = wb_rden_q;
  assign misalign_exc = mis_q;

endmodule

// File: tb/tb_pip_mem_stage.sv
// tb/tb_pip_mem_stage.sv - directed table plus randomized transactions for pip_mem_stage.
module tb_pip_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_dmem_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_rdEn;
  logic        ex_MemRead;
  logic        ex_DMwriteEn;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rdEn;
  logic        misalign_exc;

  pip_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_dmem_ctrl(ex_dmem_ctrl), .ex_rd(ex_rd),
    .ex_rdEn(ex_rdEn), .ex_MemRead(ex_MemRead), .ex_DMwriteEn(ex_DMwriteEn),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_rdEn(wb_rdEn), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic        rden;
    logic        mrd;
    logic        mwr;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data;
  logic [4:0]  last_rd;
  bit          hold_known;
  vec_t        tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic valid, input logic [31:0] alu, input logic [31:0] sdata,
                               input logic [2:0] ctrl, input logic [4:0] rd, input logic rden,
                               input logic mrd, input logic mwr, input int delay,
                               input logic [31:0] rdata, input logic [31:0] exp_data,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic exp_mis);
    vec_t v;
    v.valid = valid; v.alu = alu; v.sdata = sdata; v.ctrl = ctrl; v.rd = rd; v.rden = rden;
    v.mrd = mrd; v.mwr = mwr; v.delay = delay; v.rdata = rdata; v.exp_data = exp_data;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Reference model: access width in bytes, then plain shift/mask arithmetic.
  function automatic int unsigned nbytes(input logic [2:0] c);
    if (c == 3'd0 || c == 3'd4) return 1;
    if (c == 3'd1 || c == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int unsigned n = nbytes(c);
    int unsigned off;
    logic [31:0] mask, v;
    if (n == 4) return rdata;
    off  = (n == 1) ? (a % 4) : (a & 2);
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (rdata >> (8 * off)) & mask;
    if (c < 3'd4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t model_fill(input vec_t v);
    vec_t r = v;
    int unsigned n = nbytes(v.ctrl);
    logic mem = v.valid && (v.mrd || v.mwr);
    r.exp_mis  = TRAP && mem && (n > 1) && ((v.alu % n) != 0);
    r.exp_data = (mem && v.mrd && !v.mwr) ? model_load(v.ctrl, v.alu, v.rdata) : v.alu;
    if (n == 1) begin
      r.exp_be    = 4'(1 << (v.alu % 4));
      r.exp_wdata = {24'b0, v.sdata[7:0]} * 32'h0101_0101;
    end else if (n == 2) begin
      r.exp_be    = 4'(3 << (v.alu & 2));
      r.exp_wdata = {16'b0, v.sdata[15:0]} * 32'h0001_0001;
    end else begin
      r.exp_be    = 4'hF;
      r.exp_wdata = v.sdata;
    end
    return r;
  endfunction

  // Entered just after a rising edge; returns just after a rising edge with the stage idle.
  task automatic run_vec(input vec_t v);
    int nstall;
    ex_valid = v.valid; ex_alu_out = v.alu; ex_store_data = v.sdata; ex_dmem_ctrl = v.ctrl;
    ex_rd = v.rd; ex_rdEn = v.rden; ex_MemRead = v.mrd; ex_DMwriteEn = v.mwr; dm_ack = 1'b0;
    if (v.valid && (v.mrd || v.mwr) && !v.exp_mis) begin
      #1;
      chk("accept_stall", stall, 1);
      chk("accept_no_req", dm_req, 0);
      nstall = 1;
      @(posedge clk); #1;
      for (int k = 0; k <= v.delay; k++) begin
        dm_ack = (k == v.delay); dm_rdata = v.rdata; #1;
        chk("req", dm_req, 1);
        chk("addr", dm_addr, v.alu & ~32'd3);
        chk("we", dm_we, v.mwr);
        chk("req_wb_valid", wb_valid, 0);
        chk("req_misalign", misalign_exc, 0);
        if (v.mwr) begin
          chk("be", dm_be, v.exp_be);
          chk("wdata", dm_wdata, v.exp_wdata);
        end
        if (stall) nstall++;
        chk("req_stall", stall, (k != v.delay));
        @(posedge clk); #1;
      end
      dm_ack = 1'b0; ex_valid = 1'b0; dm_rdata = $urandom;
      chk("stall_cycles", nstall, v.delay + 1);
      chk("mem_wb_valid", wb_valid, 1);
      chk("mem_wb_data", wb_data, v.exp_data);
      chk("mem_wb_rd", wb_rd, v.rd);
      chk("mem_wb_rdEn", wb_rdEn, v.rden & ~v.mwr);
      chk("mem_misalign", misalign_exc, 0);
      last_data = v.exp_data; last_rd = v.rd; hold_known = 1'b1;
    end else begin
      dm_ack = 1'b1; #1;
      chk("nomem_stall", stall, 0);
      chk("nomem_req", dm_req, 0);
      @(posedge clk); #1;
      ex_valid = 1'b0; dm_ack = 1'b0;
      if (!v.valid) begin
        chk("idle_wb_valid", wb_valid, 0);
        if (hold_known) begin
          chk("idle_hold_data", wb_data, last_data);
          chk("idle_hold_rd", wb_rd, last_rd);
        end
      end else if (v.exp_mis) begin
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_rdEn", wb_rdEn, 0);
        chk("mis_exc", misalign_exc, 1);
        hold_known = 1'b0;
      end else begin
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, v.exp_data);
        chk("alu_wb_rd", wb_rd, v.rd);
        chk("alu_wb_rdEn", wb_rdEn, v.rden);
        chk("alu_misalign", misalign_exc, 0);
        last_data = v.exp_data; last_rd = v.rd; hold_known = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t rv;
    tbl[0]  = mkv(1, 32'h0000_1234, 32'h0, 3'b010, 5'd5, 1, 0, 0, 0, 32'h0, 32'h0000_1234, 4'h0, 32'h0, 0);
    tbl[1]  = mkv(1, 32'h0000_0103, 32'hAB, 3'b000, 5'd7, 1, 0, 1, 3, 32'h0, 32'h0000_0103, 4'b1000, 32'hABAB_ABAB, 0);
    tbl[2]  = mkv(1, 32'h0000_0202, 32'h0, 3'b000, 5'd8, 1, 1, 0, 0, 32'h0080_0000, 32'hFFFF_FF80, 4'h0, 32'h0, 0);
    tbl[3]  = mkv(1, 32'h0000_0202, 32'h0, 3'b100, 5'd9, 1, 1, 0, 0, 32'h0080_0000, 32'h0000_0080, 4'h0, 32'h0, 0);
    tbl[4]  = mkv(1, 32'h0000_0302, 32'h0, 3'b001, 5'd10, 1, 1, 0, 1, 32'h8001_0000, 32'hFFFF_8001, 4'h0, 32'h0, 0);
    tbl[5]  = mkv(1, 32'h0000_0302, 32'h0, 3'b101, 5'd11, 1, 1, 0, 0, 32'h8001_0000, 32'h0000_8001, 4'h0, 32'h0, 0);
    tbl[6]  = mkv(1, 32'h0000_0206, 32'h1234_BEEF, 3'b001, 5'd12, 1, 0, 1, 0, 32'h0, 32'h0000_0206, 4'b1100, 32'hBEEF_BEEF, 0);
    tbl[7]  = mkv(1, 32'h0000_0040, 32'hDEAD_BEEF, 3'b010, 5'd13, 0, 0, 1, 2, 32'h0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 0);
    tbl[8]  = mkv(1, 32'h0000_0500, 32'h0, 3'b011, 5'd14, 1, 1, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'h0, 32'h0, 0);
    tbl[9]  = mkv(1, 32'h0000_0401, 32'h0, 3'b010, 5'd15, 1, 1, 0, 0, 32'h1122_3344, 32'h1122_3344, 4'h0, 32'h0, TRAP);
    tbl[10] = mkv(0, 32'h0000_9999, 32'h0, 3'b010, 5'd16, 1, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
    tbl[11] = mkv(1, 32'h0000_0303, 32'h0, 3'b001, 5'd17, 1, 1, 0, 0, 32'h8001_0000, 32'hFFFF_8001, 4'h0, 32'h0, TRAP);

    rst_n = 1'b0; ex_valid = 1'b1; ex_alu_out = 32'h0000_0100; ex_store_data = 32'h0;
    ex_dmem_ctrl = 3'b010; ex_rd = 5'd1; ex_rdEn = 1'b1; ex_MemRead = 1'b1; ex_DMwriteEn = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_rdEn", wb_rdEn, 0);
    chk("rst_misalign", misalign_exc, 0);
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    last_data = 32'h0; last_rd = 5'h0; hold_known = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset while an access is outstanding abandons it.
    ex_valid = 1'b1; ex_alu_out = 32'h0000_0700; ex_dmem_ctrl = 3'b010; ex_MemRead = 1'b1;
    ex_DMwriteEn = 1'b0; ex_rd = 5'd3; ex_rdEn = 1'b1; dm_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", dm_req, 1);
    rst_n = 1'b0; #1;
    chk("midrst_req", dm_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_addr", dm_addr, 0);
    ex_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_wb_valid", wb_valid, 0);
    chk("postrst_req", dm_req, 0);
    last_data = 32'h0; last_rd = 5'h0; hold_known = 1'b1;
    run_vec(tbl[2]);

    for (int i = 0; i < 200; i++) begin
      int kind = $urandom_range(0, 3);
      rv.valid = (kind != 3);
      rv.alu   = $urandom;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.rd    = 5'($urandom);
      rv.rden  = 1'($urandom);
      rv.delay = $urandom_range(0, 3);
      rv.mrd   = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      rv.mwr   = (kind == 2);
      rv.ctrl  = 3'($urandom_range(0, 7));
      if (rv.mwr && (rv.ctrl == 3'd4 || rv.ctrl == 3'd5)) rv.ctrl = 3'd2;
      run_vec(model_fill(rv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
